// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control,
// per-result overflow/zero flags and a sticky overflow status bit.
module cla_addsub_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subtract,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             ovflow,
  output logic             zero,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);

  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned GRP  = SEG / 4;
  localparam int unsigned LAST = STAGES - 1;

  // One segment: 4-bit CLA groups chained through group generate/propagate.
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           cin);
    logic [SEG-1:0] g, p, s;
    logic [GRP:0]   gc;
    logic [3:0]     gg, pp, c;
    g     = x & y;
    p     = x ^ y;
    s     = '0;
    gc[0] = cin;
    for (int unsigned j = 0; j < GRP; j++) begin
      gg   = g[4*j +: 4];
      pp   = p[4*j +: 4];
      c[0] = gc[j];
      c[1] = gg[0] | (pp[0] & c[0]);
      c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[0]);
      c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
           | (pp[2] & pp[1] & pp[0] & c[0]);
      gc[j+1] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
              | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & c[0]);
      s[4*j +: 4] = pp ^ c;
    end
    return {gc[GRP], s};
  endfunction

  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];
  logic             sub_q   [STAGES];
  logic             sub_d   [STAGES];
  logic             sign_q  [STAGES];
  logic             sign_d  [STAGES];
  logic             ovflow_q, ovflow_d;
  logic             zero_q, zero_d;
  logic             sticky_q, sticky_d;

  logic             src_valid [STAGES];
  logic [WIDTH-1:0] src_a     [STAGES];
  logic [WIDTH-1:0] src_b     [STAGES];
  logic [WIDTH-1:0] src_sum   [STAGES];
  logic             src_cin   [STAGES];
  logic             src_sub   [STAGES];
  logic             src_sign  [STAGES];
  logic [SEG:0]     seg_c     [STAGES];
  logic [WIDTH-1:0] sum_c     [STAGES];
  logic             advance;
  logic             cout_c;
  logic             ovf_c;

  // Stage inputs: stage 0 from the ports (B inverted for subtract), others from the previous register.
  always_comb begin
    advance      = ~valid_q[LAST] | out_ready;
    src_valid[0] = in_valid;
    src_a[0]     = a;
    src_b[0]     = subtract ? ~b : b;
    src_sum[0]   = '0;
    src_cin[0]   = subtract;
    src_sub[0]   = subtract;
    src_sign[0]  = sign;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_a[k]     = a_q[k-1];
      src_b[k]     = b_q[k-1];
      src_sum[k]   = sum_q[k-1];
      src_cin[k]   = carry_q[k-1];
      src_sub[k]   = sub_q[k-1];
      src_sign[k]  = sign_q[k-1];
    end

    for (int unsigned k = 0; k < STAGES; k++) begin
      seg_c[k] = cla_seg(src_a[k][k*SEG +: SEG], src_b[k][k*SEG +: SEG], src_cin[k]);
      sum_c[k] = src_sum[k];
      sum_c[k][k*SEG +: SEG] = seg_c[k][SEG-1:0];

      valid_d[k] = valid_q[k];
      a_d[k]     = a_q[k];
      b_d[k]     = b_q[k];
      sum_d[k]   = sum_q[k];
      carry_d[k] = carry_q[k];
      sub_d[k]   = sub_q[k];
      sign_d[k]  = sign_q[k];
      if (advance) begin
        valid_d[k] = src_valid[k];
        a_d[k]     = src_a[k];
        b_d[k]     = src_b[k];
        sum_d[k]   = sum_c[k];
        carry_d[k] = seg_c[k][SEG];
        sub_d[k]   = src_sub[k];
        sign_d[k]  = src_sign[k];
      end
    end

    // Overflow and zero resolved in the last stage from the completed sum.
    cout_c = seg_c[LAST][SEG];
    if (src_sign[LAST]) begin
      ovf_c = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &&
              (sum_c[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
    end else begin
      ovf_c = src_sub[LAST] ? ~cout_c : cout_c;
    end
    ovflow_d = advance ? ovf_c : ovflow_q;
    zero_d   = advance ? (sum_c[LAST] == '0) : zero_q;
    sticky_d = (valid_q[LAST] & out_ready & ovflow_q) | (sticky_q & ~clr_sticky);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
        sub_q[k]   <= 1'b0;
        sign_q[k]  <= 1'b0;
      end
      ovflow_q <= 1'b0;
      zero_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
        sum_q[k]   <= sum_d[k];
        carry_q[k] <= carry_d[k];
        sub_q[k]   <= sub_d[k];
        sign_q[k]  <= sign_d[k];
      end
      ovflow_q <= ovflow_d;
      zero_q   <= zero_d;
      sticky_q <= sticky_d;
    end
  end

  assign in_ready   = advance;
  assign out_valid  = valid_q[LAST];
  assign res        = sum_q[LAST];
  assign ovflow     = ovflow_q;
  assign zero       = zero_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed bench for cla_addsub_pipe at WIDTH=16, STAGES=4.
module tb_cla_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, subtract, sign;
  logic        out_valid, out_ready, ovflow, zero, ovf_sticky, clr_sticky;
  logic [15:0] a, b, res;
  int          errors = 0;
  int          checks = 0;

  cla_addsub_pipe #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .subtract(subtract), .sign(sign),
    .out_valid(out_valid), .out_ready(out_ready), .res(res),
    .ovflow(ovflow), .zero(zero), .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  // Drive one beat and wait (bounded) for its result; lat=-1 on timeout.
  task automatic run_beat(input logic [15:0] av, input logic [15:0] bv,
                          input logic sb, input logic sg,
                          output logic [15:0] r, output logic o, output logic z,
                          output int lat);
    @(posedge clk); #1;
    a = av; b = bv; subtract = sb; sign = sg; in_valid = 1'b1; out_ready = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (out_valid) begin lat = i; break; end
    end
    r = res; o = ovflow; z = zero;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (res !== 16'h0) begin errors++; $display("FAIL reset_res got=%h want=0000", res); end
    checks++; if (ovflow !== 1'b0) begin errors++; $display("FAIL reset_ovflow got=%b want=0", ovflow); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero got=%b want=0", zero); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got=%b want=0", ovf_sticky); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  // Shared directed table: a, b, subtract, sign, expected res, ovflow, zero.
  task automatic test_ops();
    logic [15:0] va [11] = '{16'h0123, 16'hF123, 16'hF123, 16'h1345,
                             16'hA123, 16'hF123, 16'h2123, 16'h7123, 16'h8000,
                             16'hFFFF, 16'h0000};
    logic [15:0] vb [11] = '{16'h0345, 16'h1345, 16'h1345, 16'hF123,
                             16'hA345, 16'h1345, 16'hF345, 16'hA345, 16'h0001,
                             16'h0001, 16'h0001};
    logic        vs [11] = '{0, 0, 1, 1, 0, 0, 1, 1, 1, 0, 1};
    logic        vg [11] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0};
    logic [15:0] vr [11] = '{16'h0468, 16'h0468, 16'hDDDE, 16'h2222,
                             16'h4468, 16'h0468, 16'h2DDE, 16'hCDDE, 16'h7FFF,
                             16'h0000, 16'hFFFF};
    logic        vo [11] = '{0, 1, 0, 1, 1, 0, 0, 1, 1, 1, 1};
    logic        vz [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic [15:0] r;
    logic        o, z;
    int          lat;
    for (int i = 0; i < 11; i++) begin
      run_beat(va[i], vb[i], vs[i], vg[i], r, o, z, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL op%0d_latency got=%0d want=4", i, lat); end
      checks++; if (r !== vr[i]) begin errors++; $display("FAIL op%0d_res got=%h want=%h", i, r, vr[i]); end
      checks++; if (o !== vo[i]) begin errors++; $display("FAIL op%0d_ovflow got=%b want=%b", i, o, vo[i]); end
      checks++; if (z !== vz[i]) begin errors++; $display("FAIL op%0d_zero got=%b want=%b", i, z, vz[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_r [6];
    logic [15:0] got [$];
    int idx = 0;
    for (int i = 0; i < 6; i++) exp_r[i] = 16'(16'h1011 * i + 16'h0101 * i + 16'h0022);
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      out_ready = !(t >= 5 && t <= 9);
      in_valid  = (idx < 6);
      a = 16'(16'h1011 * idx + 16'h0011);
      b = 16'(16'h0101 * idx + 16'h0011);
      subtract = 1'b0; sign = 1'b0;
      #1;
      if (t >= 5 && t <= 9) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_stall t=%0d got=%b want=0", t, in_ready); end
        checks++; if (out_valid !== 1'b1 || res !== exp_r[1]) begin errors++; $display("FAIL b2b_held_res t=%0d got=%b/%h want=1/%h", t, out_valid, res, exp_r[1]); end
      end
      if (t <= 4 || t == 10) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready t=%0d got=%b want=1", t, in_ready); end
      end
      if (out_valid && out_ready) got.push_back(res);
      if (in_valid && in_ready) idx++;
      if (got.size() == 6) break;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got.size() != 6) begin errors++; $display("FAIL b2b_count got=%0d want=6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_r[i]) begin errors++; $display("FAIL b2b_order beat%0d got=%h want=%h", i, got[i], exp_r[i]); end
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_sticky();
    logic [15:0] r;
    logic        o, z;
    int          lat;
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clear_prior got=%b want=0", ovf_sticky); end
    run_beat(16'h0001, 16'h0001, 1'b0, 1'b0, r, o, z, lat);
    @(posedge clk); #1;
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_no_ovf got=%b want=0", ovf_sticky); end
    run_beat(16'hFFFF, 16'h0002, 1'b0, 1'b0, r, o, z, lat);
    @(posedge clk); #1;
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL sticky_set got=%b want=1", ovf_sticky); end
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clear got=%b want=0", ovf_sticky); end
    run_beat(16'h0000, 16'h0001, 1'b1, 1'b0, r, o, z, lat);
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL sticky_set_wins got=%b want=1", ovf_sticky); end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      a = 16'hFFFF; b = 16'(i + 1); subtract = 1'b0; sign = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL rstmid_sticky got=%b want=0", ovf_sticky); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale t=%0d got=%b want=0", t, out_valid); end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; subtract = 1'b0; sign = 1'b0;
    out_ready = 1'b1; clr_sticky = 1'b0;
    test_reset();
    test_ops();
    test_back_to_back();
    test_sticky();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
